// File: rtl/auction_seq.sv
// Streaming sealed-bid auction over 2**N bidders.
// Tracks top two bids; reports winner, winning bid and clearing price.
module auction_seq #(
   parameter int N = 3,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic         bid_valid,
   input  logic [W-1:0] bid,
   output logic         bid_ready,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] winner,
   output logic [W-1:0] winning_bid,
   output logic [W-1:0] price
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] idx, idx_nxt;
   logic [W-1:0] max_q, max_nxt;
   logic [W-1:0] second_q, second_nxt;
   logic [N-1:0] win_q, win_nxt;
   logic         mode_q, mode_nxt;
   logic [W-1:0] price_q, price_nxt;
   logic         hs;
   logic         last;

   assign hs   = bid_valid && (state == COLLECT);
   assign last = (idx == {N{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         max_q    <= '0;
         second_q <= '0;
         win_q    <= '0;
         mode_q   <= 1'b0;
         price_q  <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         max_q    <= max_nxt;
         second_q <= second_nxt;
         win_q    <= win_nxt;
         mode_q   <= mode_nxt;
         price_q  <= price_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      max_nxt    = max_q;
      second_nxt = second_q;
      win_nxt    = win_q;
      mode_nxt   = mode_q;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt  = COLLECT;
               idx_nxt    = '0;
               max_nxt    = '0;
               second_nxt = '0;
               win_nxt    = '0;
               mode_nxt   = mode;
            end
         end
         COLLECT: begin
            if (hs) begin
               idx_nxt = idx + 1'b1;
               // strict > keeps the lowest index on a tie,
               // while the tied bid still lifts second
               if (bid > max_q) begin
                  second_nxt = max_q;
                  max_nxt    = bid;
                  win_nxt    = idx;
               end else if (bid > second_q) begin
                  second_nxt = bid;
               end
               if (last) begin
                  state_nxt = DONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      price_nxt = mode_nxt ? second_nxt : max_nxt;
   end

   assign bid_ready   = (state == COLLECT);
   assign busy        = (state == COLLECT);
   assign done        = (state == DONE);
   assign winner      = win_q;
   assign winning_bid = max_q;
   assign price       = price_q;

endmodule

// File: tb/tb_auction_seq.sv
// Directed bench for auction_seq with hand-computed results.
module tb_auction_seq;

   localparam int N = 3;
   localparam int W = 3;

   typedef logic [W-1:0] bids_t [8];

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic         bid_valid = 1'b0;
   logic [W-1:0] bid = '0;
   logic         bid_ready;
   logic         busy;
   logic         done;
   logic [N-1:0] winner;
   logic [W-1:0] winning_bid;
   logic [W-1:0] price;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   auction_seq #(.N(N), .W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mode(mode),
      .bid_valid(bid_valid),
      .bid(bid),
      .bid_ready(bid_ready),
      .busy(busy),
      .done(done),
      .winner(winner),
      .winning_bid(winning_bid),
      .price(price)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ready"}, 32'(bid_ready), 0);
      check({tag, ".busy"}, 32'(busy), 0);
      check({tag, ".done"}, 32'(done), 0);
      check({tag, ".winner"}, 32'(winner), 0);
      check({tag, ".wbid"}, 32'(winning_bid), 0);
      check({tag, ".price"}, 32'(price), 0);
   endtask

   task automatic round(input string tag,
                        input logic m,
                        input bids_t b,
                        input bit gaps,
                        input int exp_w,
                        input int exp_wb,
                        input int exp_p,
                        input int exp_cyc);
      int cyc;
      start = 1'b1;
      mode = m;
      bid_valid = 1'b0;
      step();
      start = 1'b0;
      cyc = 0;
      check({tag, ".ready"}, 32'(bid_ready), 1);
      check({tag, ".busy"}, 32'(busy), 1);
      check({tag, ".clr_done"}, 32'(done), 0);
      check({tag, ".clr_wbid"}, 32'(winning_bid), 0);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            bid_valid = 1'b0;
            bid = 3'd7;
            if (i == 3) start = 1'b1;
            step();
            start = 1'b0;
            cyc++;
         end
         bid_valid = 1'b1;
         bid = b[i];
         step();
         cyc++;
         if (i == 6) check({tag, ".early_done"}, 32'(done), 0);
      end
      check({tag, ".done"}, 32'(done), 1);
      check({tag, ".ready_low"}, 32'(bid_ready), 0);
      check({tag, ".cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, ".winner"}, 32'(winner), 32'(exp_w));
      check({tag, ".wbid"}, 32'(winning_bid), 32'(exp_wb));
      check({tag, ".price"}, 32'(price), 32'(exp_p));
   endtask

   initial begin
      #12;
      check_zero("rst");
      step();
      rst_n = 1'b1;
      bid_valid = 1'b1;
      bid = 3'd7;
      step();
      step();
      check_zero("idle_bid");

      round("fp", 1'b0, '{6, 0, 1, 4, 7, 3, 5, 2}, 1'b0, 4, 7, 7, 8);
      // bid still offered after the last handshake must be left alone
      step();
      check("fp.hold_done", 32'(done), 1);
      check("fp.hold_winner", 32'(winner), 4);
      bid_valid = 1'b0;
      step();

      round("sp", 1'b1, '{6, 0, 1, 4, 7, 3, 5, 2}, 1'b0, 4, 7, 6, 8);
      round("tie", 1'b1, '{6, 7, 1, 4, 7, 3, 5, 2}, 1'b0, 1, 7, 7, 8);
      round("gap", 1'b0, '{6, 0, 1, 7, 4, 3, 5, 2}, 1'b1, 3, 7, 7, 16);

      start = 1'b1;
      mode = 1'b0;
      bid_valid = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bid_valid = 1'b1;
         bid = 3'(i + 5);
         step();
      end
      check("mid.busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      bid_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check_zero("post_rst");

      round("zero", 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0, 0, 0, 8);
      bid_valid = 1'b0;
      step();

      round("b2b_a", 1'b0, '{6, 0, 1, 4, 7, 3, 5, 2}, 1'b0, 4, 7, 7, 8);
      round("b2b_b", 1'b1, '{6, 0, 1, 4, 5, 3, 5, 7}, 1'b0, 7, 7, 6, 8);
      bid_valid = 1'b0;
      step();
      step();
      check("b2b.hold_done", 32'(done), 1);
      check("b2b.hold_price", 32'(price), 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/auction_seq.md
# auction_seq

Sequential, parametrised successor to the combinational `auction` block. It runs a sealed-bid auction over 2**N bidders. Bids stream in one per accepted handshake, in bidder-index order. It tracks the highest and second-highest bid and reports the winner index, the winning bid and a clearing price selected per round: first-price or second-price (Vickrey). It sits between the bid-collection front end and the result consumer, replacing the wide 2**N*W parallel bid bus with a W-bit stream.

## Interface
- N, default 3: log2 of the number of bidders; exactly 2**N bids per round.
- W, default 3: bid width in bits, unsigned.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- start  input  1: begins a round; honoured only in IDLE or DONE.
- mode  input  1: 0 = first-price, 1 = second-price; sampled when start is honoured and held for the round.
- bid_valid  input  1: bid is present.
- bid  input  W: bid of the current bidder, unsigned.
- bid_ready  output  1: block accepts a bid; high exactly in COLLECT.
- busy  output  1: high in COLLECT.
- done  output  1: high in DONE; results valid.
- winner  output  N: index of the highest bidder.
- winning_bid  output  W: highest bid.
- price  output  W: winning_bid if mode=0, otherwise the second-highest bid.

## Operation
- States: IDLE, COLLECT, DONE.
  - IDLE: start=1 → COLLECT.
  - COLLECT: after the 2**N-th accepted bid → DONE.
  - DONE: start=1 → COLLECT.
  - No other transitions.
- On honoured start:
  - index counter idx ← 0.
  - max ← 0, second ← 0, winner ← 0.
  - mode latched.
- A handshake occurs when bid_valid & bid_ready on a rising edge. The bid belongs to bidder idx, and idx increments.
- Update on a handshake with bid b:
  - If b > max: second ← max, max ← b, winner ← idx.
  - Else if b > second: second ← b.
  - Else: no change.
- Tie rule: on an equal maximum, the lowest index wins (strict >). The equal bid still raises second, so a tied top gives second-price = max.
- All comparisons are unsigned W-bit. No arithmetic widening is needed; the idx counter is N+1 bits or uses a last-bid flag to detect the final bid (index 2**N-1).
- start in COLLECT is ignored. bid_valid outside COLLECT is ignored and does not affect state.
- winner, winning_bid and price are registered. During COLLECT they show running values and are meaningful only when done=1. In DONE they hold until the next honoured start.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, idx=0, all outputs 0 (bid_ready, busy, done, winner, winning_bid, price).
- start sampled high at edge k in IDLE/DONE → bid_ready=busy=1 and done=0 after edge k. The first bid can be accepted at edge k+1.
- Best-case round: start plus 2**N back-to-back handshakes.
  - done=1 immediately after the edge that accepts the last bid.
  - Latency from the last handshake to results valid is 0 extra cycles; outputs update on that edge.
- Throughput: one bid per cycle. bid_valid gaps (bubbles) stall only the counter; no state changes.
- bid_ready drops in the same edge that raises done, so a bid held after the last handshake is not consumed.
- rst_n asserted mid-round aborts immediately to reset values. The partial round is discarded and a fresh start is required.
- Back-to-back rounds: start in the first DONE cycle is legal. done falls on the next edge.

## Test plan
- Basic, first-price: reset; start with mode=0; stream 6,0,1,4,7,3,5,2 with no bubbles.
  - Expected: done 8 cycles after bid_ready rises; winner=4, winning_bid=7, price=7.
- Second-price: same bids with mode=1.
  - Expected: winner=4, winning_bid=7, price=6.
- Tie: mode=1; bids 6,7,1,4,7,3,5,2.
  - Expected: winner=1 (lowest index), winning_bid=7, price=7.
- Bubbles and ignored inputs: mode=0; bids 6,0,1,7,4,3,5,2 with bid_valid low on alternate cycles; pulse start mid-round.
  - Expected: start has no effect; winner=3, winning_bid=7, price=7; done only after 8 handshakes.
- Reset mid-round: assert rst_n low after 4 bids.
  - Expected: all outputs 0, state IDLE, bid_ready=0.
  - Then a full round of all-zero bids with mode=1 gives winner=0, winning_bid=0, price=0.
- Back-to-back rounds:
  - Start in the first DONE cycle with mode toggled 0→1.
  - Bids 6,0,1,4,5,3,5,7 give winner=7, winning_bid=7, price=6.
  - The previous results are held until that start edge.
